cnna_mac_pipe_dsp48: RTL and testbench

//  Pipelined, parametrised multiply / multiply-accumulate unit for the CNN datapath. Next-generation DSP48 multiplier.

---
 rtl/cnna_mac_pipe_dsp48.sv | 153 +++++++++++++++
 tb/tb_cnna_mac_pipe_dsp48.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnna_mac_pipe_dsp48.sv
// rtl/cnna_mac_pipe_dsp48.sv - pipelined multiply / multiply-accumulate with shift and saturation
// Beats flow through NUM_STAGE product registers, then one accumulate/output register.
module cnna_mac_pipe_dsp48 #(
  parameter int A_WIDTH   = 15,
  parameter int B_WIDTH   = 26,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 1,
  parameter int P_WIDTH   = 32,
  parameter int ACC_WIDTH = 48,
  parameter int NUM_STAGE = 3,
  parameter int SHIFT     = 0,
  parameter int SAT       = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic               acc_en,
  input  logic [A_WIDTH-1:0] din0,
  input  logic [B_WIDTH-1:0] din1,
  output logic               out_valid,
  output logic [P_WIDTH-1:0] dout,
  output logic               sat_flag
);

  localparam bit R_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);
  localparam int PROD_W   = A_WIDTH + B_WIDTH + 2;

  typedef enum logic {ACC_IDLE, ACC_RUN} acc_state_t;

  logic signed [A_WIDTH:0]   a_ext;
  logic signed [B_WIDTH:0]   b_ext;
  logic signed [PROD_W-1:0]  prod_full;
  logic [ACC_WIDTH-1:0]      prod_acc;

  // One extra bit per operand lets a single signed multiplier cover every signedness mix.
  always_comb begin
    a_ext     = {(A_SIGNED != 0) && din0[A_WIDTH-1], din0};
    b_ext     = {(B_SIGNED != 0) && din1[B_WIDTH-1], din1};
    prod_full = PROD_W'(a_ext) * PROD_W'(b_ext);
    prod_acc  = ACC_WIDTH'(prod_full);
  end

  logic [ACC_WIDTH-1:0] p_data [NUM_STAGE];
  logic [NUM_STAGE-1:0] p_valid;
  logic [NUM_STAGE-1:0] p_acc;
  logic [NUM_STAGE-1:0] p_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid <= '0;
      p_acc   <= '0;
      p_last  <= '0;
    end else if (ce) begin
      p_valid[0] <= in_valid;
      p_acc[0]   <= acc_en;
      p_last[0]  <= in_last;
      p_data[0]  <= prod_acc;
      for (int i = 1; i < NUM_STAGE; i++) begin
        p_valid[i] <= p_valid[i-1];
        p_acc[i]   <= p_acc[i-1];
        p_last[i]  <= p_last[i-1];
        p_data[i]  <= p_data[i-1];
      end
    end
  end

  acc_state_t           state;
  logic [ACC_WIDTH-1:0] acc;
  logic                 st_valid;
  logic                 st_acc;
  logic                 st_last;
  logic [ACC_WIDTH-1:0] st_prod;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic [ACC_WIDTH-1:0] result;
  logic                 emit;

  always_comb begin
    st_valid = p_valid[NUM_STAGE-1];
    st_acc   = p_acc[NUM_STAGE-1];
    st_last  = p_last[NUM_STAGE-1];
    st_prod  = p_data[NUM_STAGE-1];
    // IDLE contributes zero, so the first beat of a group just loads the product.
    acc_sum  = ((state == ACC_RUN) ? acc : '0) + st_prod;
    result   = st_acc ? acc_sum : st_prod;
    emit     = st_valid && (!st_acc || st_last);
  end

  logic [ACC_WIDTH-1:0] shifted;
  logic [P_WIDTH-1:0]   sized;
  logic                 sat_c;

  always_comb begin
    if (R_SIGNED) shifted = $signed(result) >>> SHIFT;
    else          shifted = result >> SHIFT;
  end

  generate
    if (P_WIDTH < ACC_WIDTH) begin : g_narrow
      always_comb begin
        sized = shifted[P_WIDTH-1:0];
        sat_c = 1'b0;
        if (SAT != 0) begin
          if (R_SIGNED) begin
            // Out of range when the bits above the output sign bit are not all copies of it.
            if (shifted[ACC_WIDTH-1:P_WIDTH-1] != {(ACC_WIDTH-P_WIDTH+1){shifted[ACC_WIDTH-1]}}) begin
              sat_c = 1'b1;
              sized = shifted[ACC_WIDTH-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                                           : {1'b0, {(P_WIDTH-1){1'b1}}};
            end
          end else if (|shifted[ACC_WIDTH-1:P_WIDTH]) begin
            sat_c = 1'b1;
            sized = '1;
          end
        end
      end
    end else begin : g_wide
      always_comb begin
        if (R_SIGNED) sized = P_WIDTH'($signed(shifted));
        else          sized = P_WIDTH'(shifted);
        sat_c = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACC_IDLE;
      acc       <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      sat_flag  <= 1'b0;
    end else if (ce) begin
      out_valid <= emit;
      if (emit) begin
        dout     <= sized;
        sat_flag <= sat_c;
      end
      // Plain beats pass through without touching the group in progress.
      if (st_valid && st_acc) begin
        if (st_last) begin
          acc   <= '0;
          state <= ACC_IDLE;
        end else begin
          acc   <= acc_sum;
          state <= ACC_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnna_mac_pipe_dsp48.sv
// tb/tb_cnna_mac_pipe_dsp48.sv - directed bench for cnna_mac_pipe_dsp48
// A saturating and a wrapping instance share the same stimulus.
module tb_cnna_mac_pipe_dsp48;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic        in_last;
  logic        acc_en;
  logic [14:0] din0;
  logic [25:0] din1;
  logic        ov_s, ov_w;
  logic [31:0] dout_s, dout_w;
  logic        sf_s, sf_w;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;

  logic [31:0] out_q [$];
  int          at_q [$];
  logic        sf_q [$];

  cnna_mac_pipe_dsp48 #(.SAT(1)) u_sat (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
    .acc_en(acc_en), .din0(din0), .din1(din1),
    .out_valid(ov_s), .dout(dout_s), .sat_flag(sf_s)
  );

  cnna_mac_pipe_dsp48 #(.SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
    .acc_en(acc_en), .din0(din0), .din1(din1),
    .out_valid(ov_w), .dout(dout_w), .sat_flag(sf_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecnt = ecnt + 1;

  always @(negedge clk) begin
    if (ov_s === 1'b1) begin
      out_q.push_back(dout_s);
      at_q.push_back(ecnt);
      sf_q.push_back(sf_s);
    end
  end

  task automatic clear_q();
    out_q.delete();
    at_q.delete();
    sf_q.delete();
  endtask

  task automatic beat(input logic acc, input logic last, input logic [14:0] a, input logic [25:0] b);
    in_valid = 1'b1;
    acc_en   = acc;
    in_last  = last;
    din0     = a;
    din1     = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    acc_en   = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    checks++; if (ov_s !== 1'b0) begin errors++; $display("FAIL reset_ov got %b want 0", ov_s); end
    checks++; if (dout_s !== 32'h0) begin errors++; $display("FAIL reset_dout got %h want 0", dout_s); end
    checks++; if (sf_s !== 1'b0) begin errors++; $display("FAIL reset_sf got %b want 0", sf_s); end
    checks++; if (ov_w !== 1'b0 || dout_w !== 32'h0) begin errors++; $display("FAIL reset_wrap got %b/%h want 0/0", ov_w, dout_w); end
  endtask

  task automatic test_plain();
    int t0;
    clear_q();
    t0 = ecnt;
    beat(1'b0, 1'b0, 15'd32767, 26'h3FFFFFF);
    idle(8);
    checks++; if (out_q.size() != 1) begin errors++; $display("FAIL plain_count got %0d want 1", out_q.size()); end
    if (out_q.size() > 0) begin
      checks++; if (at_q[0] - t0 != 4) begin errors++; $display("FAIL plain_latency got %0d want 4", at_q[0] - t0); end
      checks++; if (out_q[0] !== 32'hFFFF8001) begin errors++; $display("FAIL plain_dout got %h want ffff8001", out_q[0]); end
      checks++; if (sf_q[0] !== 1'b0) begin errors++; $display("FAIL plain_sf got %b want 0", sf_q[0]); end
    end
    checks++; if (ov_s !== 1'b0 || dout_s !== 32'hFFFF8001) begin errors++; $display("FAIL plain_hold got %b/%h want 0/ffff8001", ov_s, dout_s); end
  endtask

  task automatic test_acc();
    int t0;
    clear_q();
    t0 = ecnt;
    beat(1'b1, 1'b0, 15'd100, 26'd200);
    beat(1'b1, 1'b0, 15'd100, 26'd200);
    beat(1'b1, 1'b0, 15'd100, 26'd200);
    beat(1'b1, 1'b1, 15'd100, 26'd200);
    idle(8);
    checks++; if (out_q.size() != 1) begin errors++; $display("FAIL acc_count got %0d want 1", out_q.size()); end
    if (out_q.size() > 0) begin
      checks++; if (at_q[0] - t0 != 7) begin errors++; $display("FAIL acc_latency got %0d want 7", at_q[0] - t0); end
      checks++; if (out_q[0] !== 32'd80000) begin errors++; $display("FAIL acc_dout got %0d want 80000", out_q[0]); end
    end
  endtask

  task automatic test_sat();
    clear_q();
    beat(1'b0, 1'b0, 15'd32767, 26'h1FFFFFF);
    idle(8);
    checks++; if (out_q.size() != 1) begin errors++; $display("FAIL satp_count got %0d want 1", out_q.size()); end
    if (out_q.size() > 0) begin
      checks++; if (out_q[0] !== 32'h7FFFFFFF) begin errors++; $display("FAIL satp_dout got %h want 7fffffff", out_q[0]); end
      checks++; if (sf_q[0] !== 1'b1) begin errors++; $display("FAIL satp_flag got %b want 1", sf_q[0]); end
    end
    checks++; if (dout_w !== 32'hFDFF8001) begin errors++; $display("FAIL wrapp_dout got %h want fdff8001", dout_w); end
    checks++; if (sf_w !== 1'b0) begin errors++; $display("FAIL wrapp_flag got %b want 0", sf_w); end
    clear_q();
    beat(1'b0, 1'b0, 15'd32767, 26'h2000000);
    idle(8);
    checks++; if (out_q.size() != 1) begin errors++; $display("FAIL satn_count got %0d want 1", out_q.size()); end
    if (out_q.size() > 0) begin
      checks++; if (out_q[0] !== 32'h80000000) begin errors++; $display("FAIL satn_dout got %h want 80000000", out_q[0]); end
      checks++; if (sf_q[0] !== 1'b1) begin errors++; $display("FAIL satn_flag got %b want 1", sf_q[0]); end
    end
    checks++; if (dout_w !== 32'h02000000) begin errors++; $display("FAIL wrapn_dout got %h want 02000000", dout_w); end
  endtask

  task automatic test_back_to_back();
    int exp_beat [17] = '{0, 0, 0, 1, 1, 1, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0};
    int eb;
    int k;
    logic [31:0] ev;
    for (int n = 1; n <= 18; n++) begin
      if (n >= 2) begin
        eb = exp_beat[n-2];
        checks++;
        if (ov_s !== (eb != 0)) begin errors++; $display("FAIL b2b_ov edge %0d got %b want %b", n-1, ov_s, eb != 0); end
        if (eb != 0) begin
          ev = 32'((1000 + eb) * (eb - 6));
          checks++;
          if (dout_s !== ev) begin errors++; $display("FAIL b2b_dout edge %0d got %h want %h", n-1, dout_s, ev); end
        end
      end
      if (n <= 17) begin
        k = (n <= 7) ? ((n <= 4) ? n : 5) : ((n <= 13) ? n - 3 : 0);
        ce       = !(n >= 5 && n <= 7);
        in_valid = (k != 0);
        acc_en   = 1'b0;
        in_last  = 1'b0;
        din0     = 15'(1000 + k);
        din1     = 26'(k - 6);
      end else begin
        ce       = 1'b1;
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_interleave();
    clear_q();
    beat(1'b1, 1'b0, 15'd2, 26'd3);
    beat(1'b0, 1'b0, 15'd5, 26'd7);
    beat(1'b1, 1'b0, 15'd2, 26'd3);
    beat(1'b1, 1'b1, 15'd2, 26'd3);
    idle(8);
    checks++; if (out_q.size() != 2) begin errors++; $display("FAIL inter_count got %0d want 2", out_q.size()); end
    if (out_q.size() == 2) begin
      checks++; if (out_q[0] !== 32'd35) begin errors++; $display("FAIL inter_first got %0d want 35", out_q[0]); end
      checks++; if (out_q[1] !== 32'd18) begin errors++; $display("FAIL inter_second got %0d want 18", out_q[1]); end
    end
  endtask

  task automatic test_reset_mid_group();
    beat(1'b1, 1'b0, 15'd10, 26'd10);
    beat(1'b1, 1'b0, 15'd10, 26'd10);
    idle(6);
    ce    = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ce    = 1'b1;
    checks++; if (ov_s !== 1'b0 || dout_s !== 32'h0 || sf_s !== 1'b0) begin
      errors++; $display("FAIL rst_ce_low got %b/%h/%b want 0/0/0", ov_s, dout_s, sf_s);
    end
    clear_q();
    beat(1'b1, 1'b1, 15'd1, 26'd1);
    idle(8);
    checks++; if (out_q.size() != 1) begin errors++; $display("FAIL rstmid_count got %0d want 1", out_q.size()); end
    if (out_q.size() > 0) begin
      checks++; if (out_q[0] !== 32'd1) begin errors++; $display("FAIL rstmid_dout got %0d want 1", out_q[0]); end
    end
  endtask

  initial begin
    reset    = 1'b1;
    ce       = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    acc_en   = 1'b0;
    din0     = '0;
    din1     = '0;
    @(negedge clk);
    test_reset();
    test_plain();
    test_acc();
    test_sat();
    test_back_to_back();
    test_interleave();
    test_reset_mid_group();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
